// File: rtl/spi_target_byte.sv
`default_nettype none
// ============================================================================
//  Module      : spi_target_byte
//  Description : SPI mode-0 target front-end. All SPI pins are oversampled in
//                the system clock domain. Received words and words to transmit
//                are exchanged with local logic through one-cycle strobes.
//  Ports       : clock, reset (sync, active-low)
//                sclk, pico, cs (SPI pins in), poci, poci_oe (SPI pin out)
//                tx_data / tx_taken  : next word to send / word was loaded
//                rx_data / rx_valid  : last full word / word just updated
//                busy                : a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_target_byte #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  pico,
    input  logic                  cs,
    output logic                  poci,
    output logic                  poci_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_taken,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam int                 c_SET_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_SET_W-1:0] c_SETTLE   = c_SET_W'(SYNC_STAGES + 1);

    localparam logic [1:0] S_WAIT_IDLE = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_ACTIVE    = 2'd2;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_pico_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_pico_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_pico_sync <= {r_pico_sync[SYNC_STAGES-2:0], pico};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk_s, w_pico_s, w_cs_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    // pico_s comes from the same stage as sclk_s so data/clock stay aligned
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_pico_s    = r_pico_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_rise   =  w_cs_s   & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;

    // ------------------------------------------------------------------
    // After reset the synchronizer chain still holds its reset values, which
    // would look like cs=1. Hold off the WAIT_IDLE check until real pin
    // samples have reached both cs_s and its delay flop, so a frame that was
    // in progress across reset is never joined.
    // ------------------------------------------------------------------
    logic [c_SET_W-1:0] r_settle;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_settle <= c_SETTLE;
        end else if (r_settle != '0) begin
            r_settle <= r_settle - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_IDLE: if (r_settle == '0 && w_cs_s) w_state_nxt = S_IDLE;
            S_IDLE:      if (w_cs_fall)                w_state_nxt = S_ACTIVE;
            S_ACTIVE:    if (w_cs_rise)                w_state_nxt = S_WAIT_IDLE;
            default:                                   w_state_nxt = S_WAIT_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_word_done;
    logic               w_start, w_end, w_rx_shift, w_tx_edge;
    logic               w_tx_reload, w_tx_load, w_tx_shift;

    always_comb begin
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_rx_shift  = 1'b0;
        w_tx_edge   = 1'b0;
        w_tx_reload = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_cs_fall;
            end
            S_ACTIVE: begin
                // cs rising edge wins over any sclk edge in the same cycle
                w_end      = w_cs_rise;
                w_rx_shift = ~w_cs_rise & w_sclk_rise;
                w_tx_edge  = ~w_cs_rise & w_sclk_fall;
                // next word is fetched on the falling edge that follows a
                // completed word, never on the first edge of a frame
                w_tx_reload = w_tx_edge & (r_bit_cnt == '0) & r_word_done;
            end
            default: ;
        endcase
    end

    assign w_tx_load  = w_start | w_tx_reload;
    assign w_tx_shift = w_tx_edge & ~w_tx_reload;
    assign busy       = (r_state == S_ACTIVE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_rx_pend;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
            r_rx_pend   <= 1'b0;
            poci        <= 1'b0;
            poci_oe     <= 1'b0;
            tx_taken    <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
        end else begin
            tx_taken  <= 1'b0;
            rx_valid  <= 1'b0;
            r_rx_pend <= 1'b0;

            // a completed word is published one cycle later, even if the
            // frame ends in between
            if (r_rx_pend) begin
                rx_data  <= r_rx_shift;
                rx_valid <= 1'b1;
            end

            if (w_tx_load) begin
                r_tx_shift <= tx_data;
                poci       <= tx_data[DATA_WIDTH-1];
                tx_taken   <= 1'b1;
            end

            if (w_start) begin
                poci_oe     <= 1'b1;
                r_bit_cnt   <= '0;
                r_word_done <= 1'b0;
            end

            if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                poci       <= r_tx_shift[DATA_WIDTH-2];
            end

            if (w_rx_shift) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_pico_s};
                if (r_bit_cnt == c_CNT_LAST) begin
                    r_bit_cnt   <= '0;
                    r_rx_pend   <= 1'b1;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            // partial word simply stays in the shifter and is never published
            if (w_end) begin
                poci_oe   <= 1'b0;
                poci      <= 1'b0;
                r_bit_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_target_byte.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_target_byte
//  Description : Self-checking bench for spi_target_byte. A behavioural SPI
//                controller drives frames; expected words come from queues of
//                bytes sent and bytes offered for transmission.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target_byte;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sclk  = 1'b0;
    logic       pico  = 1'b0;
    logic       cs    = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       poci, poci_oe, tx_taken, rx_valid, busy;
    logic [7:0] rx_data;

    spi_target_byte #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .pico     (pico),
        .cs       (cs),
        .poci     (poci),
        .poci_oe  (poci_oe),
        .tx_data  (tx_data),
        .tx_taken (tx_taken),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_taken = 0;
    int n_valid = 0;
    int first_taken = -1;
    int cs_cyc = 0;
    logic [7:0] rx_q[$];    // words published by the DUT
    logic [7:0] got_q[$];   // words captured by the controller on poci
    logic [7:0] send_q[$];  // words the controller sends
    logic [7:0] tx_q[$];    // words offered on tx_data, in order
    logic [7:0] last_rx = 8'h00;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset) begin
            if (tx_taken) begin
                n_taken++;
                if (first_taken < 0) first_taken = cyc;
            end
            if (rx_valid) begin
                n_valid++;
                rx_q.push_back(rx_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Clock nbits mode-0 bits: pico changes with the falling edge, the
    // controller samples poci just before each rising edge.
    task automatic clock_bits(input int nbits);
        logic [7:0] cur;
        logic [7:0] sb;
        cur = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            if (b > 0) sclk = 1'b0;
            sb   = send_q[b/8];
            pico = sb[7 - (b % 8)];
            ncyc(4);
            cur  = {cur[6:0], poci};
            if (b % 8 == 7) got_q.push_back(cur);
            sclk = 1'b1;
            if (b % 8 == 0 && (b/8 + 1) < tx_q.size()) tx_data = tx_q[b/8 + 1];
            ncyc(4);
        end
    endtask

    // cs is raised while sclk is still high, then sclk returns to idle low.
    task automatic run_frame(input int nbits);
        rx_q.delete();
        got_q.delete();
        first_taken = -1;
        tx_data = tx_q[0];
        cs      = 1'b0;
        cs_cyc  = cyc;
        ncyc(4);
        clock_bits(nbits);
        cs = 1'b1;
        ncyc(6);
        sclk = 1'b0;
        pico = 1'b0;
        ncyc(8);
    endtask

    // Reference: every full word sent is published in order, the controller
    // sees every offered word in order, one load per started word.
    task automatic frame_check(input string tag, input int nbits, input int t0, input int v0);
        int nfull;
        logic [31:0] obs;
        nfull = nbits / 8;
        check({tag, "_taken"}, n_taken - t0, 1 + (nbits - 1) / 8);
        check({tag, "_valid"}, n_valid - v0, nfull);
        for (int i = 0; i < nfull; i++) begin
            obs = (rx_q.size() > i) ? {24'h0, rx_q[i]} : 32'hxxxxxxxx;
            check({tag, "_rx"}, obs, {24'h0, send_q[i]});
            obs = (got_q.size() > i) ? {24'h0, got_q[i]} : 32'hxxxxxxxx;
            check({tag, "_poci"}, obs, {24'h0, tx_q[i]});
        end
        if (nfull > 0) last_rx = send_q[nfull - 1];
        check({tag, "_rxdata"}, rx_data, last_rx);
        check({tag, "_oe"}, poci_oe, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int t0, v0, nb;

        // 1: reset with cs idle
        ncyc(4);
        check("rst_poci", poci, 1'b0);
        check("rst_oe", poci_oe, 1'b0);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_taken", tx_taken, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rxdata", rx_data, 8'h00);
        reset = 1'b1;
        ncyc(10);
        check("idle_pulses", n_taken + n_valid, 0);
        check("idle_busy", busy, 1'b0);

        // 2: single byte
        send_q = '{8'h3C};
        tx_q   = '{8'hA5};
        t0 = n_taken; v0 = n_valid;
        run_frame(8);
        check("single_latency", first_taken - cs_cyc, 3);
        frame_check("single", 8, t0, v0);

        // 3: two bytes in one frame
        send_q = '{8'h01, 8'hFF};
        tx_q   = '{8'hA5, 8'h5A};
        t0 = n_taken; v0 = n_valid;
        run_frame(16);
        frame_check("b2b", 16, t0, v0);

        // 4: abort after 5 bits, then a clean frame
        send_q = '{8'($urandom)};
        tx_q   = '{8'($urandom)};
        t0 = n_taken; v0 = n_valid;
        run_frame(5);
        frame_check("abort", 5, t0, v0);
        send_q = '{8'($urandom)};
        tx_q   = '{8'($urandom)};
        t0 = n_taken; v0 = n_valid;
        run_frame(8);
        frame_check("post_abort", 8, t0, v0);

        // 5: reset in the middle of a frame
        send_q = '{8'($urandom)};
        tx_q   = '{8'($urandom)};
        tx_data = tx_q[0];
        cs = 1'b0;
        ncyc(4);
        clock_bits(3);
        sclk = 1'b0;
        ncyc(2);
        reset = 1'b0;
        ncyc(4);
        check("midrst_rxdata", rx_data, 8'h00);
        last_rx = 8'h00;
        reset = 1'b1;
        t0 = n_taken; v0 = n_valid;
        clock_bits(5);
        ncyc(4);
        check("midrst_taken", n_taken - t0, 0);
        check("midrst_valid", n_valid - v0, 0);
        check("midrst_oe", poci_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        cs = 1'b1;
        ncyc(6);
        sclk = 1'b0;
        ncyc(8);
        send_q = '{8'($urandom)};
        tx_q   = '{8'($urandom)};
        t0 = n_taken; v0 = n_valid;
        run_frame(8);
        frame_check("post_rst", 8, t0, v0);

        // 6: sclk toggling with cs high
        t0 = n_taken; v0 = n_valid;
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1;
            ncyc(4);
            sclk = 1'b0;
            ncyc(4);
        end
        check("spur_taken", n_taken - t0, 0);
        check("spur_valid", n_valid - v0, 0);
        check("spur_oe", poci_oe, 1'b0);

        // randomized multi-byte frames
        for (int f = 0; f < 4; f++) begin
            nb = $urandom_range(1, 3);
            send_q.delete();
            tx_q.delete();
            for (int i = 0; i < nb; i++) begin
                send_q.push_back(8'($urandom));
                tx_q.push_back(8'($urandom));
            end
            t0 = n_taken; v0 = n_valid;
            run_frame(8 * nb);
            frame_check("rand", 8 * nb, t0, v0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_target_byte.md
Name: spi_target_byte

Overview:
- SPI target (peripheral) stage that sits directly downstream of the rvsteel SPI controller on the board-level top.
- Consumes the controller's sclk/pico/cs and produces poci back to it.
- Oversamples all SPI pins in the single system clock domain and exchanges bytes with local logic through simple valid/taken strobes.
- Serves as an on-board loopback/echo target for SPI demos and as a reusable target front-end.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; MSB first.
- SYNC_STAGES, 2, synchronizer flops on sclk, pico and cs; minimum 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- sclk  input  1  SPI clock from the controller; mode 0 (CPOL=0, CPHA=0).
- pico  input  1  controller-out/target-in data.
- cs  input  1  chip select, active-low.
- poci  output  1  target-out/controller-in data.
- poci_oe  output  1  output enable for the poci pad; 1 = drive.
- tx_data  input  DATA_WIDTH  next word to transmit; must be stable when tx_taken pulses.
- tx_taken  output  1  one-cycle pulse when tx_data has been loaded into the shifter.
- rx_data  output  DATA_WIDTH  last fully received word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  1 while a frame is active (state ACTIVE).

Behaviour:
- Synchronizers:
  - sclk, pico and cs each pass through SYNC_STAGES flops.
  - A further flop on sclk_s/cs_s gives edge detection.
  - pico_s is taken from the same stage as sclk_s, so data and clock stay aligned.
- Timing constraint: sclk high and low phases must each be >= SYNC_STAGES+2 clock cycles. With defaults, clock >= 8x sclk.
- Reset (reset=0 on a clock edge):
  - State = WAIT_IDLE, poci=0, poci_oe=0, tx_taken=0, rx_valid=0, rx_data=0, busy=0, bit counter=0, shifters=0.
  - All synchronizer flops reset to 1 for cs and 0 for sclk/pico.
- FSM states: WAIT_IDLE, IDLE, ACTIVE.
  - WAIT_IDLE: wait for cs_s=1, then go to IDLE. This prevents joining a frame mid-way after a reset. Also the post-frame state.
  - IDLE -> ACTIVE on cs_s falling edge. In the same cycle:
    - load tx_data into tx shifter;
    - pulse tx_taken;
    - poci = tx_data[DATA_WIDTH-1];
    - poci_oe = 1;
    - bit counter = 0.
  - ACTIVE, sclk_s rising edge:
    - shift pico_s into the rx shifter LSB;
    - increment the bit counter.
    - When the counter reaches DATA_WIDTH: on the next cycle rx_data = completed word and rx_valid pulses for 1 cycle; counter wraps to 0.
  - ACTIVE, sclk_s falling edge:
    - If the counter is 0 and at least one word has completed in this frame: load tx_data, pulse tx_taken, poci = new MSB.
    - Otherwise shift the tx shifter left and poci = next bit.
  - ACTIVE -> WAIT_IDLE on cs_s rising edge:
    - poci_oe=0 and poci=0 in the same cycle;
    - a partial word (counter != 0) is discarded, with no rx_valid and rx_data unchanged;
    - a completed word's rx_valid is still issued if pending.
- Simultaneous events:
  - A cs_s rising edge takes priority over an sclk_s edge in the same cycle; the sclk edge is ignored.
  - rx_valid and tx_taken may pulse in the same cycle only if timing permits; both are independent.
- sclk edges outside ACTIVE are ignored.
- Latency:
  - pin sclk rise -> rx shifter update: SYNC_STAGES+1 cycles;
  - last rising sclk -> rx_valid: SYNC_STAGES+2 cycles;
  - pin cs fall -> poci valid: SYNC_STAGES+1 cycles.
- busy = (state == ACTIVE).

Test Plan:
1. Reset then idle: hold reset=0 for 4 cycles with cs=1 -> poci=0, poci_oe=0, rx_valid=0, tx_taken=0, busy=0. After release, state reaches IDLE with no pulses.
2. Single byte, sclk=clock/8, tx_data=8'hA5, controller sends 8'h3C:
   - tx_taken pulses once, SYNC_STAGES+1 cycles after cs falls;
   - poci bits sampled at sclk rises = 1,0,1,0,0,1,0,1;
   - rx_valid pulses once with rx_data=8'h3C;
   - after cs rises, poci_oe=0.
3. Back-to-back two bytes in one frame: tx_data changed to 8'h5A after the first tx_taken; controller sends 8'h01 then 8'hFF:
   - controller receives 8'hA5 then 8'h5A;
   - rx_valid pulses twice with 8'h01 then 8'hFF;
   - tx_taken pulses twice.
4. Abort: cs deasserted after 5 sclk rises -> no rx_valid, rx_data retains its previous value, busy=0. The next frame receives a full byte correctly.
5. Reset mid-frame: assert reset after 3 bits with cs held low, release, then clock 5 more bits -> no rx_valid, poci_oe=0. Only after cs goes high then low does a new frame produce a correct byte.
6. Spurious sclk: toggle sclk 8 times with cs=1 -> no rx_valid, no tx_taken, poci_oe=0.
